reg_file_mp: RTL

Parametrised multi-port register file with pending-write scoreboard. It is the successor to the 8x16 processor register file: width and depth are parameters, there are two independent write ports with separate addresses, and reads are clocked with write-first bypass. Per-register busy bits support hazard detection in the decode stage. It sits between decode (read and reserve) and writeback (write ports W1 and W2).

---
 rtl/reg_file_mp_if.sv | 44 ++++
 rtl/reg_file_mp.sv | 117 +++++++++++
 2 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle between decode/writeback (master) and the multi-port register file (slave).
// Port groups: read (rd_en/ra/rb -> bus_a/bus_b/busy_a/busy_b), two write ports and a reserve port.
interface reg_file_mp_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   // Handshake: there is no valid/ready pair. rd_en, we1, we2 and rsv_en are single-cycle
   // qualifiers sampled on the rising clock edge. The register file never back-pressures,
   // so every enabled request is accepted on the edge where it is seen.
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] ra;
   logic [ADDR_WIDTH-1:0] rb;
   logic [DATA_WIDTH-1:0] bus_a;
   logic [DATA_WIDTH-1:0] bus_b;
   logic                  busy_a;
   logic                  busy_b;

   logic                  we1;
   logic                  we2;
   logic [ADDR_WIDTH-1:0] rw1;
   logic [ADDR_WIDTH-1:0] rw2;
   logic [DATA_WIDTH-1:0] bus_w1;
   logic [DATA_WIDTH-1:0] bus_w2;

   logic                  rsv_en;
   logic [ADDR_WIDTH-1:0] rsv_addr;
   logic [NUM_REGS-1:0]   busy_vec;

   modport master (
      output rd_en, ra, rb,
      output we1, we2, rw1, rw2, bus_w1, bus_w2,
      output rsv_en, rsv_addr,
      input  bus_a, bus_b, busy_a, busy_b, busy_vec
   );

   modport slave (
      input  rd_en, ra, rb,
      input  we1, we2, rw1, rw2, bus_w1, bus_w2,
      input  rsv_en, rsv_addr,
      output bus_a, bus_b, busy_a, busy_b, busy_vec
   );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised register file: two write ports, two clocked read ports with write-first
// bypass, and a per-register busy scoreboard for decode-stage hazard detection.
module reg_file_mp #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int ZERO_REG   = 1
) (
   input logic            clock,
   input logic            reset_n,
   reg_file_mp_if.slave   bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_busy;
   logic [DATA_WIDTH-1:0] r_bus_a;
   logic [DATA_WIDTH-1:0] r_bus_b;
   logic                  r_busy_a;
   logic                  r_busy_b;

   logic                  w_we1;
   logic                  w_we2;
   logic                  w_zero_ra;
   logic                  w_zero_rb;
   logic [NUM_REGS-1:0]   w_set;
   logic [NUM_REGS-1:0]   w_clr;
   logic [NUM_REGS-1:0]   w_busy_next;
   logic [DATA_WIDTH-1:0] w_rd_a;
   logic [DATA_WIDTH-1:0] w_rd_b;

   // Register 0 is hard-wired to zero when ZERO_REG is set: writes and reads are masked here.
   assign w_we1     = bus.we1 && !((ZERO_REG != 0) && (bus.rw1 == '0));
   assign w_we2     = bus.we2 && !((ZERO_REG != 0) && (bus.rw2 == '0));
   assign w_zero_ra = (ZERO_REG != 0) && (bus.ra == '0);
   assign w_zero_rb = (ZERO_REG != 0) && (bus.rb == '0);

   always_comb begin
      w_set       = '0;
      w_clr       = '0;
      w_busy_next = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_set[i] = bus.rsv_en && (bus.rsv_addr == ADDR_WIDTH'(i)) &&
                    !((ZERO_REG != 0) && (i == 0));
         w_clr[i] = (bus.we1 && (bus.rw1 == ADDR_WIDTH'(i))) ||
                    (bus.we2 && (bus.rw2 == ADDR_WIDTH'(i)));
         // A new reservation supersedes a same-edge writeback to the same register.
         w_busy_next[i] = w_set[i] | (r_busy[i] & ~w_clr[i]);
      end
   end

   // Write-first bypass, W2 ahead of W1 to match the storage priority.
   always_comb begin
      w_rd_a = r_regs[bus.ra];
      if (w_zero_ra) begin
         w_rd_a = '0;
      end else if (w_we2 && (bus.rw2 == bus.ra)) begin
         w_rd_a = bus.bus_w2;
      end else if (w_we1 && (bus.rw1 == bus.ra)) begin
         w_rd_a = bus.bus_w1;
      end
   end

   always_comb begin
      w_rd_b = r_regs[bus.rb];
      if (w_zero_rb) begin
         w_rd_b = '0;
      end else if (w_we2 && (bus.rw2 == bus.rb)) begin
         w_rd_b = bus.bus_w2;
      end else if (w_we1 && (bus.rw1 == bus.rb)) begin
         w_rd_b = bus.bus_w1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_we1) begin
            r_regs[bus.rw1] <= bus.bus_w1;
         end
         // Later assignment wins, so W2 takes a colliding address.
         if (w_we2) begin
            r_regs[bus.rw2] <= bus.bus_w2;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_bus_a  <= '0;
         r_bus_b  <= '0;
         r_busy_a <= 1'b0;
         r_busy_b <= 1'b0;
      end else if (bus.rd_en) begin
         r_bus_a  <= w_rd_a;
         r_bus_b  <= w_rd_b;
         r_busy_a <= w_busy_next[bus.ra];
         r_busy_b <= w_busy_next[bus.rb];
      end
   end

   assign bus.bus_a    = r_bus_a;
   assign bus.bus_b    = r_bus_b;
   assign bus.busy_a   = r_busy_a;
   assign bus.busy_b   = r_busy_b;
   assign bus.busy_vec = r_busy;
endmodule
